// File: rtl/sio_frame_rx_pkg.sv
// Shared SIO definitions: frame field sizes, start nibble, CRC constants, FSM states.
package sio_frame_rx_pkg;

    localparam int unsigned ADDR_NIBBLES   = 4;
    localparam int unsigned DATA_NIBBLES   = 16;
    localparam int unsigned STREAM_NIBBLES = 4;
    localparam int unsigned CRC_NIBBLES    = 4;
    localparam int unsigned NIB_CNT_W      = 5;

    localparam logic [3:0]  START_NIBBLE = 4'h0;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    // x^16 + x^15 + x^2 + 1
    localparam logic [15:0] CRC_POLY     = 16'h8005;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_STREAM = 3'd3,
        ST_CRC    = 3'd4
    } sio_state_e;

    // Advance the CRC by one nibble; nibble bits enter LSB first, CRC shifts MSB out.
    function automatic logic [15:0] crc16_step4(input logic [15:0] crc_in,
                                                input logic [3:0]  nib);
        logic [15:0] v_crc;
        logic        v_fb;
        v_crc = crc_in;
        for (int i = 0; i < 4; i++) begin
            v_fb  = v_crc[15] ^ nib[i];
            v_crc = {v_crc[14:0], 1'b0};
            if (v_fb) begin
                v_crc = v_crc ^ CRC_POLY;
            end
        end
        return v_crc;
    endfunction

endpackage

// File: rtl/crc_16_4_usb.sv
// Nibble-wide CRC-16 (x^16+x^15+x^2+1) register with synchronous init and enable.
module crc_16_4_usb
    import sio_frame_rx_pkg::*;
(
    input  logic        c,
    input  logic        r,
    input  logic        ce,
    input  logic [3:0]  d,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    // Init has priority over update so a start nibble always seeds the register.
    always_ff @(posedge c) begin
        if (r) begin
            r_crc <= CRC_INIT;
        end else if (ce) begin
            r_crc <= crc16_step4(r_crc, d);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sio_frame_rx.sv
// SIO host-to-target frame receiver: deframes 29-nibble frames and checks the CRC.
module sio_frame_rx
    import sio_frame_rx_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             c,
    input  logic             r,
    input  logic [3:0]       rd,
    output logic             valid,
    output logic [15:0]      addr,
    output logic [63:0]      data,
    output logic [15:0]      stream,
    output logic             crc_err,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    sio_state_e           r_state;
    logic [NIB_CNT_W-1:0] r_cnt;
    logic                 r_busy;

    logic [15:0]          r_addr_sr;
    logic [63:0]          r_data_sr;
    logic [15:0]          r_stream_sr;
    logic [15:0]          r_crc_sr;

    logic                 r_valid;
    logic                 r_crc_err;
    logic [15:0]          r_addr;
    logic [63:0]          r_data;
    logic [15:0]          r_stream;
    logic [CNT_W-1:0]     r_err_cnt;

    logic                 w_start;
    logic                 w_crc_init;
    logic                 w_crc_ce;
    logic                 w_last_crc;
    logic [15:0]          w_crc_calc;
    logic [15:0]          w_rx_crc;

    assign w_start    = (r_state == ST_IDLE) && (rd == START_NIBBLE);
    assign w_crc_init = r || w_start;
    // Stream top nibble is carried in the frame but excluded from the CRC.
    assign w_crc_ce   = (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                        ((r_state == ST_STREAM) &&
                         (r_cnt != NIB_CNT_W'(STREAM_NIBBLES - 1)));
    assign w_last_crc = (r_state == ST_CRC) && (r_cnt == NIB_CNT_W'(CRC_NIBBLES - 1));
    // Received CRC completed by the nibble currently on the line.
    assign w_rx_crc   = {rd, r_crc_sr[15:4]};

    crc_16_4_usb u_crc (
        .c   (c),
        .r   (w_crc_init),
        .ce  (w_crc_ce),
        .d   (rd),
        .crc (w_crc_calc)
    );

    // Frame sequencer: walks the fields, counting nibbles within each.
    always_ff @(posedge c) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ADDR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == NIB_CNT_W'(ADDR_NIBBLES - 1)) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + NIB_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == NIB_CNT_W'(DATA_NIBBLES - 1)) begin
                        r_state <= ST_STREAM;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + NIB_CNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (r_cnt == NIB_CNT_W'(STREAM_NIBBLES - 1)) begin
                        r_state <= ST_CRC;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + NIB_CNT_W'(1);
                    end
                end
                ST_CRC: begin
                    if (w_last_crc) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + NIB_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Field shift registers: each nibble enters at the top so nibble 0 lands in [3:0].
    always_ff @(posedge c) begin
        if (r) begin
            r_addr_sr   <= '0;
            r_data_sr   <= '0;
            r_stream_sr <= '0;
            r_crc_sr    <= '0;
        end else begin
            case (r_state)
                ST_ADDR:   r_addr_sr   <= {rd, r_addr_sr[15:4]};
                ST_DATA:   r_data_sr   <= {rd, r_data_sr[63:4]};
                ST_STREAM: r_stream_sr <= {rd, r_stream_sr[15:4]};
                ST_CRC:    r_crc_sr    <= {rd, r_crc_sr[15:4]};
                default:   ;
            endcase
        end
    end

    // Frame verdict: publish fields on a match, otherwise pulse the error and count it.
    always_ff @(posedge c) begin
        if (r) begin
            r_valid   <= 1'b0;
            r_crc_err <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_stream  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_valid   <= 1'b0;
            r_crc_err <= 1'b0;
            if (w_last_crc) begin
                if (w_rx_crc == w_crc_calc) begin
                    r_valid  <= 1'b1;
                    r_addr   <= r_addr_sr;
                    r_data   <= r_data_sr;
                    r_stream <= r_stream_sr;
                end else begin
                    r_crc_err <= 1'b1;
                    if (r_err_cnt != {CNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign valid     = r_valid;
    assign crc_err   = r_crc_err;
    assign addr      = r_addr;
    assign data      = r_data;
    assign stream    = r_stream;
    assign err_count = r_err_cnt;
    assign busy      = r_busy;

endmodule
